s2b_cnt: RTL and testbench

Stochastic-to-binary converter in the scu stage ahead of the binary multiplier. Accepts a unipolar stochastic bitstream and counts its ones over a fixed window of 2^INWD valid bits. Publishes the count as an INWD-bit binary operand, saturated at full scale, with a one-cycle valid strobe. Two instances supply the iA/iB operands of the downstream multiplier; the result register holds its value between windows.

---
 rtl/s2b_cnt.sv | 100 ++++++++++
 tb/tb_s2b_cnt.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/s2b_cnt.sv
`default_nettype none
// ============================================================================
// s2b_cnt : counts ones of a unipolar stochastic bitstream over 2^INWD valid
//           samples and publishes the saturated INWD-bit binary value.
// Rev 1.0
// ============================================================================
module s2b_cnt #(
  parameter int INWD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iStart,
  input  logic            iEn,
  input  logic            iBit,
  output logic [INWD-1:0] oC,
  output logic            oValid,
  output logic            oBusy
);

  localparam logic [0:0]      S_IDLE   = 1'b0;
  localparam logic [0:0]      S_ACC    = 1'b1;
  localparam logic [INWD-1:0] LAST_IDX = '1;

  logic [0:0]      state_q,   state_d;
  logic [INWD-1:0] bit_cnt_q, bit_cnt_d;
  logic [INWD:0]   one_cnt_q, one_cnt_d;
  logic [INWD-1:0] c_q,       c_d;
  logic            valid_q,   valid_d;

  logic            last_sample;
  logic [INWD:0]   ones_sum;

  assign last_sample = (state_q == S_ACC) && iEn && (bit_cnt_q == LAST_IDX);
  assign ones_sum    = one_cnt_q + {{INWD{1'b0}}, iBit};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iStart)      state_d = S_ACC;
      S_ACC:   if (last_sample) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    oBusy = (state_q == S_ACC);
  end

  // Counters and result datapath
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    one_cnt_d = one_cnt_q;
    c_d       = c_q;
    valid_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (iStart) begin
        bit_cnt_d = '0;
        one_cnt_d = '0;
      end
    end else if (iEn) begin
      bit_cnt_d = bit_cnt_q + INWD'(1'b1);
      one_cnt_d = ones_sum;
    end
    // A full window of ones reaches 2^INWD, one past the largest INWD-bit code
    if (last_sample) begin
      valid_d = 1'b1;
      c_d     = ones_sum[INWD] ? LAST_IDX : ones_sum[INWD-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      one_cnt_q <= '0;
      c_q       <= '0;
      valid_q   <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      one_cnt_q <= one_cnt_d;
      c_q       <= c_d;
      valid_q   <= valid_d;
    end
  end

  assign oC     = c_q;
  assign oValid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_s2b_cnt.sv
`default_nettype none
// ============================================================================
// tb_s2b_cnt : randomized self-checking bench for s2b_cnt against a
//              sample-queue reference model.
// Rev 1.0
// ============================================================================
module tb_s2b_cnt;

  localparam int INWD = 8;
  localparam int NWIN = 1 << INWD;
  localparam int MAXC = NWIN - 1;

  logic            clk;
  logic            rst;
  logic            iStart;
  logic            iEn;
  logic            iBit;
  logic [INWD-1:0] oC;
  logic            oValid;
  logic            oBusy;

  int n_tests;
  int n_fail;
  int cyc;

  // Reference model state: samples accepted in the current window
  bit ref_busy;
  bit ref_valid;
  int ref_c;
  bit samples[$];

  s2b_cnt #(.INWD(INWD)) dut (
    .clk    (clk),
    .rst    (rst),
    .iStart (iStart),
    .iEn    (iEn),
    .iBit   (iBit),
    .oC     (oC),
    .oValid (oValid),
    .oBusy  (oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit st, input bit en, input bit b, input bit r);
    int s;
    if (r) begin
      ref_busy  = 1'b0;
      ref_valid = 1'b0;
      ref_c     = 0;
      samples.delete();
    end else begin
      ref_valid = 1'b0;
      if (!ref_busy) begin
        if (st) begin
          ref_busy = 1'b1;
          samples.delete();
        end
      end else if (en) begin
        samples.push_back(b);
        if (samples.size() == NWIN) begin
          s = 0;
          foreach (samples[i]) s += samples[i];
          ref_c     = (s > MAXC) ? MAXC : s;
          ref_valid = 1'b1;
          ref_busy  = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input bit st, input bit en, input bit b, input bit r);
    rst    = r;
    iStart = st;
    iEn    = en;
    iBit   = b;
    @(posedge clk);
    cyc++;
    model_edge(st, en, b, r);
    #1;
    check_eq("oC", int'(oC), ref_c);
    check_eq("oValid", int'(oValid), int'(ref_valid));
    check_eq("oBusy", int'(oBusy), int'(ref_busy));
  endtask

  function automatic bit pat(input int mode, input int idx, input int zpos);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (idx % 2) == 0;
      3:       return idx != zpos;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  // One window: start cycle, then NWIN samples with `gaps` iEn=0 cycles mixed in
  task automatic run_window(input int mode, input int gaps, input bit gap_bit,
                            input int pulse_at, input int exp_c, output int lat);
    bit en_seq[$];
    int zpos;
    int idx;
    int t0;
    zpos = $urandom_range(0, NWIN - 1);
    for (int k = 0; k < NWIN; k++) en_seq.push_back(1'b1);
    for (int k = 0; k < gaps; k++) en_seq.insert($urandom_range(0, en_seq.size() - 1), 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    t0  = cyc;
    idx = 0;
    foreach (en_seq[k]) begin
      if (en_seq[k]) begin
        step(idx == pulse_at, 1'b1, pat(mode, idx, zpos), 1'b0);
        idx++;
      end else begin
        step(1'b0, 1'b0, gap_bit, 1'b0);
      end
    end
    lat = cyc - t0 + 1;
    check_eq("win_valid", int'(oValid), 1);
    check_eq("win_busy", int'(oBusy), 0);
    check_eq("win_latency", lat, NWIN + 1 + gaps);
    if (exp_c >= 0) check_eq("win_result", int'(oC), exp_c);
  endtask

  initial begin
    int lat;
    int v1;
    int nvalid;
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    ref_busy  = 1'b0;
    ref_valid = 1'b0;
    ref_c     = 0;
    rst       = 1'b1;
    iStart    = 1'b0;
    iEn       = 1'b0;
    iBit      = 1'b0;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("reset_busy", int'(oBusy), 0);
    check_eq("reset_c", int'(oC), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    run_window(0, 0, 1'b0, -1, 255, lat);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("valid_one_cycle", int'(oValid), 0);
    run_window(1, 0, 1'b0, -1, 0, lat);
    run_window(2, 0, 1'b0, -1, 128, lat);
    run_window(3, 0, 1'b0, -1, 255, lat);

    run_window(0, 100, 1'b0, -1, 255, lat);
    run_window(0, 100, 1'b1, -1, 255, lat);

    run_window(0, 0, 1'b0, 50, 255, lat);

    // Back-to-back: the next start is driven in the oValid cycle
    v1 = cyc;
    run_window(0, 0, 1'b0, -1, 255, lat);
    check_eq("b2b_spacing", cyc - v1, NWIN + 1);

    // Reset in the middle of a window
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 128; i++) step(1'b0, 1'b1, (i % 2) == 0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("midrst_busy", int'(oBusy), 0);
    check_eq("midrst_c", int'(oC), 0);
    nvalid = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
      if (oValid) nvalid++;
    end
    check_eq("midrst_no_valid", nvalid, 0);
    run_window(0, 0, 1'b0, -1, 255, lat);

    // Hold between windows
    run_window(2, 0, 1'b0, -1, 128, lat);
    nvalid = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
      if (oValid) nvalid++;
    end
    check_eq("hold_c", int'(oC), 128);
    check_eq("hold_no_valid", nvalid, 0);

    for (int w = 0; w < 4; w++) begin
      run_window(4, $urandom_range(0, 20), 1'($urandom % 2),
                 $urandom_range(0, NWIN - 1), -1, lat);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
